// File: rtl/sobel_matrix_3x3.sv
// rtl/sobel_matrix_3x3.sv - 3x3 pixel window builder feeding the Sobel detector.
// Optional MATRIX_BORDER_ZERO_EN: zero the window taps that fall outside the image.
module sobel_matrix_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          pix_en,
  input  logic [DW-1:0] pix_data,
  output logic          matrix_en,
  output logic [DW-1:0] p11,
  output logic [DW-1:0] p12,
  output logic [DW-1:0] p13,
  output logic [DW-1:0] p21,
  output logic [DW-1:0] p22,
  output logic [DW-1:0] p23,
  output logic [DW-1:0] p31,
  output logic [DW-1:0] p32,
  output logic [DW-1:0] p33
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  // frame_start coincident with a pixel makes that pixel (0,0)
  assign cur_col = frame_start ? '0 : col_cnt;
  assign cur_row = frame_start ? '0 : row_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pix_en) begin
      if (cur_col == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_cnt <= cur_col + 1'b1;
        row_cnt <= cur_row;
      end
    end else if (frame_start) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end
  end

  logic          s1_valid;
  logic [DW-1:0] s1_pix;
  logic [CW-1:0] s1_col;
`ifdef MATRIX_BORDER_ZERO_EN
  logic [RW-1:0] s1_row;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_col   <= '0;
`ifdef MATRIX_BORDER_ZERO_EN
      s1_row   <= '0;
`endif
    end else begin
      s1_valid <= pix_en;
      if (pix_en) begin
        s1_pix <= pix_data;
        s1_col <= cur_col;
`ifdef MATRIX_BORDER_ZERO_EN
        s1_row <= cur_row;
`endif
      end
    end
  end

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb0_q;
  logic [DW-1:0] lb1_q;

  // lb1 takes the value lb0 held at stage-1 read time, so the line shifts down intact
  always_ff @(posedge clk) begin
    lb0_q <= lb0[cur_col];
    lb1_q <= lb1[cur_col];
    if (s1_valid && !rst) begin
      lb0[s1_col] <= s1_pix;
      lb1[s1_col] <= lb0_q;
    end
  end

  logic row_lt1;
  logic row_lt2;
  logic col_lt1;
  logic col_lt2;

`ifdef MATRIX_BORDER_ZERO_EN
  localparam logic [RW-1:0] ROW_ONE = RW'(1);
  localparam logic [CW-1:0] COL_ONE = CW'(1);
  assign row_lt1 = (s1_row == '0);
  assign row_lt2 = (s1_row <= ROW_ONE);
  assign col_lt1 = (s1_col == '0);
  assign col_lt2 = (s1_col <= COL_ONE);
`else
  assign row_lt1 = 1'b0;
  assign row_lt2 = 1'b0;
  assign col_lt1 = 1'b0;
  assign col_lt2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_en <= 1'b0;
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else begin
      matrix_en <= s1_valid;
      if (s1_valid) begin
        p11 <= (row_lt2 || col_lt2) ? '0 : p12;
        p12 <= (row_lt2 || col_lt1) ? '0 : p13;
        p13 <= row_lt2 ? '0 : lb1_q;
        p21 <= (row_lt1 || col_lt2) ? '0 : p22;
        p22 <= (row_lt1 || col_lt1) ? '0 : p23;
        p23 <= row_lt1 ? '0 : lb0_q;
        p31 <= col_lt2 ? '0 : p32;
        p32 <= col_lt1 ? '0 : p33;
        p33 <= s1_pix;
      end
    end
  end

endmodule

// File: tb/tb_sobel_matrix_3x3.sv
// tb/tb_sobel_matrix_3x3.sv - scoreboard bench for sobel_matrix_3x3 on an 8x6 image.
module tb_sobel_matrix_3x3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_en;
  logic [DW-1:0] pix_data;
  logic          matrix_en;
  logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  always #5 clk = ~clk;

  sobel_matrix_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_en(pix_en),
    .pix_data(pix_data), .matrix_en(matrix_en),
    .p11(p11), .p12(p12), .p13(p13),
    .p21(p21), .p22(p22), .p23(p23),
    .p31(p31), .p32(p32), .p33(p33)
  );

  typedef struct {
    int due;
    int row;
    int col;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  bit   mon_on = 1'b0;
  int   m_row  = 0;
  int   m_col  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_clear(input string tag);
    chk({tag, " matrix_en"}, matrix_en, 0);
    chk({tag, " p11"}, p11, 0); chk({tag, " p12"}, p12, 0); chk({tag, " p13"}, p13, 0);
    chk({tag, " p21"}, p21, 0); chk({tag, " p22"}, p22, 0); chk({tag, " p23"}, p23, 0);
    chk({tag, " p31"}, p31, 0); chk({tag, " p32"}, p32, 0); chk({tag, " p33"}, p33, 0);
  endtask

  // Expected tap (i,j) of pixel (r,c) is the pixel at (r-2+i, c-2+j) when inside the image
  always @(negedge clk) begin : mon
    logic [7:0] taps [9];
    exp_t e;
    int rr, cc;
    if (mon_on) begin
      taps = '{p11, p12, p13, p21, p22, p23, p31, p32, p33};
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        chk($sformatf("window for (%0d,%0d) missing", e.row, e.col), 0, 1);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("matrix_en", matrix_en, 1);
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            rr = e.row - 2 + i;
            cc = e.col - 2 + j;
            if (rr >= 0 && cc >= 0)
              chk($sformatf("(%0d,%0d) p%0d%0d", e.row, e.col, i + 1, j + 1),
                  taps[i*3+j], {rr[3:0], cc[3:0]});
`ifdef MATRIX_BORDER_ZERO_EN
            else
              chk($sformatf("(%0d,%0d) border p%0d%0d", e.row, e.col, i + 1, j + 1),
                  taps[i*3+j], 0);
`endif
          end
        end
      end else begin
        chk("matrix_en idle", matrix_en, 0);
      end
    end
  end

  task automatic step(input bit r, input bit fs, input bit en);
    rst         = r;
    frame_start = fs;
    pix_en      = en;
    pix_data    = DW'($urandom);
    if (r) begin
      m_row = 0;
      m_col = 0;
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    end else begin
      if (fs) begin
        m_row = 0;
        m_col = 0;
      end
      if (en) begin
        pix_data = {m_row[3:0], m_col[3:0]};
        sb.push_back('{cyc + 2, m_row, m_col});
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row = (m_row + 1) % H;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  bit pat [6] = '{1, 0, 0, 1, 1, 0};

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_en = 1'b0; pix_data = '0;
    step(1, 0, 0);
    step(1, 0, 0);
    check_clear("reset");
    mon_on = 1'b1;

    step(0, 1, 0);
    repeat (49) step(0, 0, 1);

    for (int i = 0; i < 12; i++) step(0, 0, pat[i % 6]);

    step(0, 1, 0);
    repeat (13) step(0, 0, 1);
    step(0, 1, 1);
    repeat (20) step(0, 0, 1);

    repeat (3) step(0, 0, 1);
    step(1, 0, 1);
    check_clear("rst mid-row");
    repeat (20) step(0, 0, 1);

    repeat (150) step(0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);
    repeat (4) step(0, 0, 0);
    chk("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
